mac_ctrl: RTL and testbench

MAC_CTRL -- requirements
Module: mac_ctrl

---
 rtl/mac_ctrl.sv | 139 +++++++++++++
 tb/tb_mac_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mac_ctrl.sv
// rtl/mac_ctrl.sv - tile sequencer for a row x col MAC array: kernel load, activation stream, drain
module mac_ctrl #(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int len_bw  = 8,
  parameter int addr_bw = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [len_bw-1:0]  num_vec,
  input  logic [addr_bw-1:0] w_base,
  input  logic [addr_bw-1:0] x_base,
  input  logic               stall,
  output logic               cen,
  output logic [addr_bw-1:0] addr,
  output logic [1:0]         inst_w,
  output logic               busy,
  output logic               done
);

  // One counter serves LOAD (row words), EXEC (num_vec words) and DRAIN (row+col cycles),
  // so it must be wide enough for whichever of those is largest.
  localparam int drain_bw = $clog2(row + col + 1);
  localparam int cnt_bw   = (drain_bw > len_bw) ? drain_bw : len_bw;

  localparam logic [cnt_bw-1:0] load_last  = cnt_bw'(row - 1);
  localparam logic [cnt_bw-1:0] drain_last = cnt_bw'(row + col - 1);
  localparam logic [cnt_bw-1:0] cnt_one    = cnt_bw'(1);

  typedef enum logic [2:0] {IDLE, LOAD, EXEC, DRAIN, DONE} state_t;

  state_t             state, state_next;
  logic [cnt_bw-1:0]  cnt, cnt_next, cnt_inc;
  logic [len_bw-1:0]  num_vec_q;
  logic [addr_bw-1:0] w_base_q, x_base_q, last_addr, rd_addr;
  logic               rd_load, rd_exec, latch;

  assign cnt_inc = cnt + cnt_one;

  // Next-state, counter and per-cycle read decisions; a stalled EXEC cycle issues nothing.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    rd_load    = 1'b0;
    rd_exec    = 1'b0;
    latch      = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          latch      = 1'b1;
          cnt_next   = '0;
          state_next = LOAD;
        end
      end
      LOAD: begin
        rd_load = 1'b1;
        if (cnt == load_last) begin
          cnt_next   = '0;
          state_next = (num_vec_q == '0) ? DRAIN : EXEC;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      EXEC: begin
        if (!stall) begin
          rd_exec = 1'b1;
          if (cnt_inc == cnt_bw'(num_vec_q)) begin
            cnt_next   = '0;
            state_next = DRAIN;
          end else begin
            cnt_next = cnt_inc;
          end
        end
      end
      DRAIN: begin
        if (cnt == drain_last) begin
          cnt_next   = '0;
          state_next = DONE;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Address follows the running counter in LOAD/EXEC (held while stalled), otherwise the last read.
  always_comb begin
    rd_addr = last_addr;
    if (state == LOAD) begin
      rd_addr = w_base_q + addr_bw'(cnt);
    end else if (state == EXEC) begin
      rd_addr = x_base_q + addr_bw'(cnt);
    end
  end

  assign cen  = ~(rd_load | rd_exec);
  assign addr = rd_addr;
  assign busy = (state != IDLE);

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Counter, latched tile parameters, held address, and array instruction delayed to match SRAM latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      num_vec_q <= '0;
      w_base_q  <= '0;
      x_base_q  <= '0;
      last_addr <= '0;
      inst_w    <= 2'b00;
    end else begin
      cnt    <= cnt_next;
      inst_w <= {rd_exec, rd_load};
      if (latch) begin
        num_vec_q <= num_vec;
        w_base_q  <= w_base;
        x_base_q  <= x_base;
      end
      if (rd_load | rd_exec) begin
        last_addr <= rd_addr;
      end
    end
  end

endmodule

// File: tb/tb_mac_ctrl.sv
// tb/tb_mac_ctrl.sv - directed tile-trace bench for mac_ctrl
module tb_mac_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic [7:0]  num_vec = '0;
  logic [10:0] w_base = '0;
  logic [10:0] x_base = '0;
  logic        cen;
  logic [10:0] addr;
  logic [1:0]  inst_w;
  logic        busy;
  logic        done;

  int total = 0;
  int bad = 0;
  int n = 0;

  logic        t_cen [64];
  logic [10:0] t_addr [64];
  logic [1:0]  t_inst [64];
  logic        t_busy [64];
  logic        t_done [64];

  logic        e_cen [64];
  logic [10:0] e_addr [64];
  bit          e_ac [64];
  logic [1:0]  e_inst [64];
  logic        e_busy [64];
  logic        e_done [64];

  mac_ctrl #(.row(8), .col(8), .len_bw(8), .addr_bw(11)) dut (
    .clk(clk), .reset(reset), .start(start), .num_vec(num_vec),
    .w_base(w_base), .x_base(x_base), .stall(stall), .cen(cen),
    .addr(addr), .inst_w(inst_w), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // One clock: inputs change 2 units after the rising edge, outputs recorded on the falling edge.
  task automatic step(input logic s_start, input logic s_stall, input logic s_rst);
    @(posedge clk);
    #2;
    start = s_start;
    stall = s_stall;
    reset = s_rst;
    @(negedge clk);
    t_cen[n]  = cen;
    t_addr[n] = addr;
    t_inst[n] = inst_w;
    t_busy[n] = busy;
    t_done[n] = done;
    n++;
  endtask

  task automatic clear_exp();
    for (int c = 0; c < 64; c++) begin
      e_cen[c] = 1'b1; e_addr[c] = '0; e_ac[c] = 1'b0;
      e_inst[c] = 2'b00; e_busy[c] = 1'b0; e_done[c] = 1'b0;
    end
    n = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++; if (cen !== 1'b1) begin bad++; $display("FAIL reset_cen got=%b exp=1", cen); end
    total++; if (addr !== 11'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", addr); end
    total++; if (inst_w !== 2'b00) begin bad++; $display("FAIL reset_inst got=%b exp=00", inst_w); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  // num_vec=4, w_base=0, x_base=16: loads 1..8, exec 9..12, drain 13..28, done 29.
  task automatic test_basic(input string tag);
    clear_exp();
    num_vec = 8'd4; w_base = 11'd0; x_base = 11'd16;
    for (int c = 0; c < 32; c++) step(c == 0, 1'b0, 1'b0);
    e_ac[0] = 1'b1; e_addr[0] = 11'd0;
    for (int c = 1; c <= 29; c++) e_busy[c] = 1'b1;
    for (int c = 1; c <= 8; c++) begin e_cen[c] = 1'b0; e_addr[c] = 11'(c - 1); e_ac[c] = 1'b1; end
    for (int c = 9; c <= 12; c++) begin e_cen[c] = 1'b0; e_addr[c] = 11'(16 + c - 9); e_ac[c] = 1'b1; end
    for (int c = 13; c < 32; c++) begin e_addr[c] = 11'd19; e_ac[c] = 1'b1; end
    for (int c = 2; c <= 9; c++) e_inst[c] = 2'b01;
    for (int c = 10; c <= 13; c++) e_inst[c] = 2'b10;
    e_done[29] = 1'b1;
    for (int c = 0; c < n; c++) begin
      total++; if (t_cen[c] !== e_cen[c]) begin bad++; $display("FAIL %s_cen c=%0d got=%b exp=%b", tag, c, t_cen[c], e_cen[c]); end
      if (e_ac[c]) begin total++; if (t_addr[c] !== e_addr[c]) begin bad++; $display("FAIL %s_addr c=%0d got=%0d exp=%0d", tag, c, t_addr[c], e_addr[c]); end end
      total++; if (t_inst[c] !== e_inst[c]) begin bad++; $display("FAIL %s_inst c=%0d got=%b exp=%b", tag, c, t_inst[c], e_inst[c]); end
      total++; if (t_busy[c] !== e_busy[c]) begin bad++; $display("FAIL %s_busy c=%0d got=%b exp=%b", tag, c, t_busy[c], e_busy[c]); end
      total++; if (t_done[c] !== e_done[c]) begin bad++; $display("FAIL %s_done c=%0d got=%b exp=%b", tag, c, t_done[c], e_done[c]); end
    end
  endtask

  // Same tile with stall high in cycles 11..13 (right after the 2nd exec read): done moves to 32.
  task automatic test_stall();
    clear_exp();
    num_vec = 8'd4; w_base = 11'd0; x_base = 11'd16;
    for (int c = 0; c < 36; c++) step(c == 0, (c >= 11 && c <= 13), 1'b0);
    for (int c = 1; c <= 32; c++) e_busy[c] = 1'b1;
    for (int c = 1; c <= 8; c++) begin e_cen[c] = 1'b0; e_addr[c] = 11'(c - 1); e_ac[c] = 1'b1; end
    e_cen[9] = 1'b0;  e_addr[9] = 11'd16;  e_ac[9] = 1'b1;
    e_cen[10] = 1'b0; e_addr[10] = 11'd17; e_ac[10] = 1'b1;
    for (int c = 11; c <= 13; c++) begin e_addr[c] = 11'd18; e_ac[c] = 1'b1; end
    e_cen[14] = 1'b0; e_addr[14] = 11'd18; e_ac[14] = 1'b1;
    e_cen[15] = 1'b0; e_addr[15] = 11'd19; e_ac[15] = 1'b1;
    for (int c = 16; c < 36; c++) begin e_addr[c] = 11'd19; e_ac[c] = 1'b1; end
    for (int c = 2; c <= 9; c++) e_inst[c] = 2'b01;
    e_inst[10] = 2'b10; e_inst[11] = 2'b10; e_inst[15] = 2'b10; e_inst[16] = 2'b10;
    e_done[32] = 1'b1;
    for (int c = 0; c < n; c++) begin
      total++; if (t_cen[c] !== e_cen[c]) begin bad++; $display("FAIL stall_cen c=%0d got=%b exp=%b", c, t_cen[c], e_cen[c]); end
      if (e_ac[c]) begin total++; if (t_addr[c] !== e_addr[c]) begin bad++; $display("FAIL stall_addr c=%0d got=%0d exp=%0d", c, t_addr[c], e_addr[c]); end end
      total++; if (t_inst[c] !== e_inst[c]) begin bad++; $display("FAIL stall_inst c=%0d got=%b exp=%b", c, t_inst[c], e_inst[c]); end
      total++; if (t_busy[c] !== e_busy[c]) begin bad++; $display("FAIL stall_busy c=%0d got=%b exp=%b", c, t_busy[c], e_busy[c]); end
      total++; if (t_done[c] !== e_done[c]) begin bad++; $display("FAIL stall_done c=%0d got=%b exp=%b", c, t_done[c], e_done[c]); end
    end
  endtask

  // num_vec=0: loads only (100..107), drain 9..24, done 25, never an execute instruction.
  task automatic test_zero();
    clear_exp();
    num_vec = 8'd0; w_base = 11'd100; x_base = 11'd50;
    for (int c = 0; c < 28; c++) step(c == 0, 1'b0, 1'b0);
    for (int c = 1; c <= 25; c++) e_busy[c] = 1'b1;
    for (int c = 1; c <= 8; c++) begin e_cen[c] = 1'b0; e_addr[c] = 11'(99 + c); e_ac[c] = 1'b1; end
    for (int c = 9; c < 28; c++) begin e_addr[c] = 11'd107; e_ac[c] = 1'b1; end
    for (int c = 2; c <= 9; c++) e_inst[c] = 2'b01;
    e_done[25] = 1'b1;
    for (int c = 0; c < n; c++) begin
      total++; if (t_cen[c] !== e_cen[c]) begin bad++; $display("FAIL zero_cen c=%0d got=%b exp=%b", c, t_cen[c], e_cen[c]); end
      if (e_ac[c]) begin total++; if (t_addr[c] !== e_addr[c]) begin bad++; $display("FAIL zero_addr c=%0d got=%0d exp=%0d", c, t_addr[c], e_addr[c]); end end
      total++; if (t_inst[c] !== e_inst[c]) begin bad++; $display("FAIL zero_inst c=%0d got=%b exp=%b", c, t_inst[c], e_inst[c]); end
      total++; if (t_busy[c] !== e_busy[c]) begin bad++; $display("FAIL zero_busy c=%0d got=%b exp=%b", c, t_busy[c], e_busy[c]); end
      total++; if (t_done[c] !== e_done[c]) begin bad++; $display("FAIL zero_done c=%0d got=%b exp=%b", c, t_done[c], e_done[c]); end
    end
  endtask

  // w_base=2045, x_base=2047, num_vec=2: both address streams wrap through 0.
  task automatic test_wrap();
    logic [10:0] load_addrs [8];
    load_addrs = '{11'd2045, 11'd2046, 11'd2047, 11'd0, 11'd1, 11'd2, 11'd3, 11'd4};
    clear_exp();
    num_vec = 8'd2; w_base = 11'd2045; x_base = 11'd2047;
    for (int c = 0; c < 30; c++) step(c == 0, 1'b0, 1'b0);
    for (int c = 1; c <= 27; c++) e_busy[c] = 1'b1;
    for (int c = 1; c <= 8; c++) begin e_cen[c] = 1'b0; e_addr[c] = load_addrs[c - 1]; e_ac[c] = 1'b1; end
    e_cen[9] = 1'b0;  e_addr[9] = 11'd2047; e_ac[9] = 1'b1;
    e_cen[10] = 1'b0; e_addr[10] = 11'd0;   e_ac[10] = 1'b1;
    for (int c = 11; c < 30; c++) begin e_addr[c] = 11'd0; e_ac[c] = 1'b1; end
    for (int c = 2; c <= 9; c++) e_inst[c] = 2'b01;
    e_inst[10] = 2'b10; e_inst[11] = 2'b10;
    e_done[27] = 1'b1;
    for (int c = 0; c < n; c++) begin
      total++; if (t_cen[c] !== e_cen[c]) begin bad++; $display("FAIL wrap_cen c=%0d got=%b exp=%b", c, t_cen[c], e_cen[c]); end
      if (e_ac[c]) begin total++; if (t_addr[c] !== e_addr[c]) begin bad++; $display("FAIL wrap_addr c=%0d got=%0d exp=%0d", c, t_addr[c], e_addr[c]); end end
      total++; if (t_inst[c] !== e_inst[c]) begin bad++; $display("FAIL wrap_inst c=%0d got=%b exp=%b", c, t_inst[c], e_inst[c]); end
      total++; if (t_busy[c] !== e_busy[c]) begin bad++; $display("FAIL wrap_busy c=%0d got=%b exp=%b", c, t_busy[c], e_busy[c]); end
      total++; if (t_done[c] !== e_done[c]) begin bad++; $display("FAIL wrap_done c=%0d got=%b exp=%b", c, t_done[c], e_done[c]); end
    end
  endtask

  // Extra start pulses with different parameters in LOAD (c=3) and DRAIN (c=15) must change nothing.
  task automatic test_ignore_start();
    clear_exp();
    num_vec = 8'd3; w_base = 11'd10; x_base = 11'd40;
    for (int c = 0; c < 36; c++) begin
      if (c == 3)  begin num_vec = 8'd7; w_base = 11'd500; x_base = 11'd600; end
      if (c == 15) begin num_vec = 8'd9; w_base = 11'd300; x_base = 11'd700; end
      step((c == 0 || c == 3 || c == 15), 1'b0, 1'b0);
    end
    for (int c = 1; c <= 28; c++) e_busy[c] = 1'b1;
    for (int c = 1; c <= 8; c++) begin e_cen[c] = 1'b0; e_addr[c] = 11'(9 + c); e_ac[c] = 1'b1; end
    for (int c = 9; c <= 11; c++) begin e_cen[c] = 1'b0; e_addr[c] = 11'(40 + c - 9); e_ac[c] = 1'b1; end
    for (int c = 12; c < 36; c++) begin e_addr[c] = 11'd42; e_ac[c] = 1'b1; end
    for (int c = 2; c <= 9; c++) e_inst[c] = 2'b01;
    for (int c = 10; c <= 12; c++) e_inst[c] = 2'b10;
    e_done[28] = 1'b1;
    for (int c = 0; c < n; c++) begin
      total++; if (t_cen[c] !== e_cen[c]) begin bad++; $display("FAIL ignore_cen c=%0d got=%b exp=%b", c, t_cen[c], e_cen[c]); end
      if (e_ac[c]) begin total++; if (t_addr[c] !== e_addr[c]) begin bad++; $display("FAIL ignore_addr c=%0d got=%0d exp=%0d", c, t_addr[c], e_addr[c]); end end
      total++; if (t_inst[c] !== e_inst[c]) begin bad++; $display("FAIL ignore_inst c=%0d got=%b exp=%b", c, t_inst[c], e_inst[c]); end
      total++; if (t_busy[c] !== e_busy[c]) begin bad++; $display("FAIL ignore_busy c=%0d got=%b exp=%b", c, t_busy[c], e_busy[c]); end
      total++; if (t_done[c] !== e_done[c]) begin bad++; $display("FAIL ignore_done c=%0d got=%b exp=%b", c, t_done[c], e_done[c]); end
    end
  endtask

  // Reset raised during the 3rd exec read (cycle 11): outputs drop at once, no done afterwards.
  task automatic test_reset_mid();
    int dones;
    int busies;
    clear_exp();
    num_vec = 8'd4; w_base = 11'd0; x_base = 11'd16;
    for (int c = 0; c <= 10; c++) step(c == 0, 1'b0, 1'b0);
    total++; if (t_addr[10] !== 11'd17 || t_cen[10] !== 1'b0) begin bad++; $display("FAIL midrst_pre got=%0d/%b exp=17/0", t_addr[10], t_cen[10]); end
    step(1'b0, 1'b0, 1'b1);
    total++; if (t_cen[11] !== 1'b1) begin bad++; $display("FAIL midrst_cen got=%b exp=1", t_cen[11]); end
    total++; if (t_addr[11] !== 11'd0) begin bad++; $display("FAIL midrst_addr got=%0d exp=0", t_addr[11]); end
    total++; if (t_inst[11] !== 2'b00) begin bad++; $display("FAIL midrst_inst got=%b exp=00", t_inst[11]); end
    total++; if (t_busy[11] !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", t_busy[11]); end
    total++; if (t_done[11] !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b exp=0", t_done[11]); end
    dones = 0;
    busies = 0;
    for (int c = 0; c < 30; c++) begin
      step(1'b0, 1'b0, 1'b0);
      if (t_done[n - 1] === 1'b1) dones++;
      if (t_busy[n - 1] !== 1'b0) busies++;
    end
    total++; if (dones !== 0) begin bad++; $display("FAIL midrst_no_done got=%0d exp=0", dones); end
    total++; if (busies !== 0) begin bad++; $display("FAIL midrst_idle got=%0d busy cycles exp=0", busies); end
  endtask

  initial begin
    test_reset();
    test_basic("basic");
    test_stall();
    test_zero();
    test_wrap();
    test_ignore_start();
    test_reset_mid();
    test_basic("after_reset");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
